// File: rtl/ps2_kbd_mmio_pkg.sv
// Shared constants and types for the memory-mapped PS/2 keyboard receiver.
// Bus encodings match the data-memory port; register offsets are decoded from addr[3:2].
package ps2_kbd_mmio_pkg;

    localparam logic        MEM_READ       = 1'b0;
    localparam logic        MEM_WRITE      = 1'b1;

    localparam logic [31:0] KBD_BASE       = 32'ha1000000;
    localparam logic [1:0]  KBD_REG_DATA   = 2'd0;
    localparam logic [1:0]  KBD_REG_STATUS = 2'd1;

    localparam int unsigned STAT_OVERFLOW  = 8;
    localparam int unsigned STAT_FRAME_ERR = 9;
    localparam int unsigned STAT_EMPTY     = 10;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_t;

    // Odd parity over the data byte plus the parity bit, and a high stop bit.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return (^{data, par}) & stop;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, falling-edge detect, frame FSM and
// inactivity timeout. Emits a one-cycle byte_valid or byte_err when a frame completes.
module ps2_rx
    import ps2_kbd_mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 6000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   clk_s, din, fall;

    rx_state_t state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign din   = data_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        // A stalled partial frame is dropped silently once the line has been quiet too long.
        if (state_q != StIdle) begin
            if (fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = '0;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (fall) begin
            case (state_q)
                StIdle: begin
                    if (!din) begin
                        state_d  = StData;
                        bitcnt_d = '0;
                        tmo_d    = '0;
                    end
                end
                StData: begin
                    shift_d  = {din, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = din;
                    state_d = StStop;
                end
                StStop: begin
                    if (frame_ok(shift_q, par_q, din)) valid_d = 1'b1;
                    else                               err_d   = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

endmodule

// File: rtl/ps2_kbd_mmio.sv
// Memory-mapped PS/2 keyboard: scancode FIFO behind a DATA/STATUS register pair with
// registered read data and an irq that is high while scancodes are pending.
module ps2_kbd_mmio
    import ps2_kbd_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 6000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ena,
    input  logic        mem_rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0] rx_byte;
    logic       byte_valid, byte_err;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic [31:0]   rdata_q, rdata_d, status;
    logic          irq_q;
    logic [1:0]    sel;
    logic          rd_acc, wr_acc, empty, full, push, pop, clr_wr;

    logic unused_bus;
    assign unused_bus = ^{addr[31:4], addr[1:0], wdata[31:10], wdata[7:0]};

    always_comb begin
        sel    = addr[3:2];
        rd_acc = ena && (mem_rw == MEM_READ);
        wr_acc = ena && (mem_rw == MEM_WRITE);
        clr_wr = wr_acc && (sel == KBD_REG_STATUS);
        empty  = (count_q == '0);
        full   = (count_q == CW'(FIFO_DEPTH));
        pop    = rd_acc && (sel == KBD_REG_DATA) && !empty;
        // A pop in the same cycle frees the slot the incoming byte needs.
        push   = byte_valid && (!full || pop);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (clr_wr && wdata[STAT_OVERFLOW])  overflow_d  = 1'b0;
        if (clr_wr && wdata[STAT_FRAME_ERR]) frame_err_d = 1'b0;
        if (byte_valid && !push)             overflow_d  = 1'b1;
        if (byte_err)                        frame_err_d = 1'b1;

        status                 = '0;
        status[7:0]            = 8'(count_q);
        status[STAT_OVERFLOW]  = overflow_q;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_EMPTY]     = empty;

        rdata_d = rdata_q;
        if (rd_acc) begin
            case (sel)
                KBD_REG_DATA:   rdata_d = empty ? '0 : {23'b0, 1'b1, fifo_mem[rd_ptr_q]};
                KBD_REG_STATUS: rdata_d = status;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
            irq_q       <= (count_q != '0);
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// Directed bench for ps2_kbd_mmio: table of single frames plus hand-written sequences for
// overflow, timeout, simultaneous push/pop and mid-frame reset.
module tb_ps2_kbd_mmio;
    import ps2_kbd_mmio_pkg::*;

    localparam int HALF = 20;  // PS/2 half period in system clocks, well under the timeout

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ena = 1'b0;
    logic        mem_rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    ps2_kbd_mmio #(
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (200),
        .SYNC_STAGES    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ena      (ena),
        .mem_rw   (mem_rw),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        par_flip;
        logic        stop;
        logic [31:0] exp_status;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All tasks start and end 1 ns after a rising clock edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [1:0] sel, output logic [31:0] d);
        ena    = 1'b1;
        mem_rw = MEM_READ;
        addr   = {28'b0, sel, 2'b00};
        tick(1);
        ena = 1'b0;
        d   = rdata;
    endtask

    task automatic bus_write(input logic [1:0] sel, input logic [31:0] val);
        ena    = 1'b1;
        mem_rw = MEM_WRITE;
        addr   = {28'b0, sel, 2'b00};
        wdata  = val;
        tick(1);
        ena = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b1, 11);
    endtask

    initial begin
        logic [31:0] d;
        logic        got_pulse;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 32'h001, 32'h11C, 1'b1};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 32'h600, 32'h000, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 32'h001, 32'h1FF, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 32'h001, 32'h100, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 32'h600, 32'h000, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 32'h001, 32'h180, 1'b1};
        vecs[6] = '{8'h81, 1'b1, 1'b0, 32'h600, 32'h000, 1'b0};

        tick(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        tick(2);
        bus_read(KBD_REG_STATUS, d);
        check("reset_status", d, 32'h400);

        foreach (vecs[i]) begin
            send_bits(vecs[i].b, vecs[i].par_flip, vecs[i].stop, 11);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
            bus_read(KBD_REG_STATUS, d);
            check($sformatf("vec%0d_status", i), d, vecs[i].exp_status);
            bus_read(KBD_REG_DATA, d);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            bus_write(KBD_REG_STATUS, 32'h300);
            bus_read(KBD_REG_STATUS, d);
            check($sformatf("vec%0d_cleared", i), d, 32'h400);
        end

        // irq drops one cycle after the pop empties the FIFO.
        send_frame(8'h1C);
        bus_read(KBD_REG_DATA, d);
        check("pop_rdata", d, 32'h11C);
        check("irq_before_update", {31'b0, irq}, 32'h1);
        tick(1);
        check("irq_after_update", {31'b0, irq}, 32'h0);

        // 17 frames into a 16-deep FIFO.
        for (int i = 0; i <= 16; i++) send_frame(8'(i));
        bus_read(KBD_REG_STATUS, d);
        check("overflow_status", d, 32'h110);
        for (int i = 0; i < 16; i++) begin
            bus_read(KBD_REG_DATA, d);
            check($sformatf("drain%0d", i), d, 32'h100 + 32'(i));
        end
        bus_read(KBD_REG_DATA, d);
        check("drain_empty", d, 32'h0);
        bus_write(KBD_REG_STATUS, 32'h200);
        bus_read(KBD_REG_STATUS, d);
        check("clear_frame_err_only", d, 32'h500);
        bus_write(KBD_REG_STATUS, 32'h100);
        bus_read(KBD_REG_STATUS, d);
        check("clear_overflow", d, 32'h400);
        bus_read(2'd2, d);
        check("reg2_reads_zero", d, 32'h0);

        // Partial frame abandoned by the timeout, then a complete one.
        send_bits(8'hFF, 1'b0, 1'b1, 5);
        tick(300);
        send_frame(8'hF0);
        bus_read(KBD_REG_STATUS, d);
        check("timeout_status", d, 32'h001);
        bus_read(KBD_REG_DATA, d);
        check("timeout_data", d, 32'h1F0);

        // Pop in the same cycle as a push into a full FIFO.
        for (int i = 0; i < 16; i++) send_frame(8'(i));
        bus_read(KBD_REG_STATUS, d);
        check("full_status", d, 32'h010);
        got_pulse = 1'b0;
        fork
            send_frame(8'h10);
            begin
                for (int k = 0; k < 2000 && !got_pulse; k++) begin
                    if (dut.byte_valid) got_pulse = 1'b1;
                    else tick(1);
                end
                if (got_pulse) begin
                    bus_read(KBD_REG_DATA, d);
                    check("simul_pop_data", d, 32'h100);
                end
            end
        join
        check("simul_pulse_seen", {31'b0, got_pulse}, 32'h1);
        bus_read(KBD_REG_STATUS, d);
        check("simul_status", d, 32'h010);
        for (int i = 1; i <= 16; i++) begin
            bus_read(KBD_REG_DATA, d);
            check($sformatf("simul_drain%0d", i), d, 32'h100 + 32'(i));
        end

        // Reset in the middle of a frame.
        send_frame(8'h33);
        bus_read(KBD_REG_STATUS, d);
        check("pre_reset_status", d, 32'h001);
        send_bits(8'h55, 1'b0, 1'b1, 4);
        #3 rst = 1'b1;
        #1;
        check("mid_reset_rdata", rdata, 32'h0);
        check("mid_reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        send_frame(8'h5A);
        bus_read(KBD_REG_STATUS, d);
        check("post_reset_status", d, 32'h001);
        bus_read(KBD_REG_DATA, d);
        check("post_reset_data", d, 32'h15A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_mmio.md
Name: ps2_kbd_mmio

Overview:
Memory-mapped PS/2 keyboard receiver. It is the input-direction counterpart of the write-only VGA text terminal.
- Deserialises PS/2 device-to-host frames and buffers scancode bytes in a FIFO.
- The core reads the FIFO through the shared data-memory bus, mapped in the top-level decoder at 0xa1000000–0xa100000f.
- irq flags pending input.

Parameters:
FIFO_DEPTH, 16, scancode FIFO entries; must be a power of 2, minimum 2.
TIMEOUT_CYCLES, 6000, clk cycles (120 us at 50 MHz) without a ps2_clk falling edge before a partial frame is discarded.
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data.

Ports:
clk  in  1  system clock (CLOCK_50 domain); the only clock.
rst  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock from the device, asynchronous.
ps2_data  in  1  raw PS/2 data from the device, asynchronous.
ena  in  1  bus select from the top-level address decoder.
mem_rw  in  1  `MEM_READ / `MEM_WRITE, same encoding as the RAM port.
addr  in  32  byte offset from base (mem_addr - 32'ha1000000); bits [3:2] decoded.
wdata  in  32  write data.
rdata  out  32  registered read data.
irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (async, rst=1): the following clear immediately:
  - rdata=0, irq=0.
  - FIFO empty, count=0.
  - overflow=0, frame_err=0.
  - Receiver in IDLE, timeout counter 0, synchronisers to 1.
- Synchronisation: ps2_clk and ps2_data each pass SYNC_STAGES flops. A falling edge is detected when the previous synced clk=1 and the current synced clk=0. Data is sampled on that same cycle.
- Receiver FSM (sub-module ps2_rx):
  - IDLE: an edge with data=0 (start bit) moves to DATA, bitcnt=0. An edge with data=1 is ignored.
  - DATA: 8 edges shift data LSB first, then the FSM moves to PARITY.
  - PARITY: one edge latches the parity bit, then the FSM moves to STOP.
  - STOP: one edge latches the stop bit. Frame is good if popcount(data)+parity is odd AND stop=1.
  - On completing STOP, the FSM emits a 1-cycle byte_valid (good frame) or byte_err (bad frame), then returns to IDLE.
  - Timeout: in any state other than IDLE, TIMEOUT_CYCLES consecutive cycles without an edge return the FSM to IDLE silently, with no flag. The counter restarts on every edge.
- FIFO:
  - byte_valid pushes when count<FIFO_DEPTH. When full, the byte is dropped and overflow is set; FIFO contents are unchanged.
  - byte_err sets frame_err.
- Register map, selected by addr[3:2]:
  - 0 DATA (R): returns {23'b0, valid, byte}. When non-empty, valid=1 and the head entry is popped. When empty, the read returns 0 and nothing changes.
  - 1 STATUS (R): [7:0]=count (zero-extended), [8]=overflow, [9]=frame_err, [10]=empty. Other bits are 0.
  - 1 STATUS (W): wdata[8]=1 clears overflow; wdata[9]=1 clears frame_err.
  - 2 and 3: reads return 0; writes are ignored.
  - Writes to DATA are ignored.
- Bus timing:
  - Every clk cycle with ena=1 is exactly one access. The decoder guarantees single-cycle strobes.
  - Read data is registered: rdata is valid the cycle after the access and holds until the next read access.
  - A pop takes effect at the access edge, so a read in cycle N+1 sees the next entry.
- Simultaneous events:
  - Push and pop in the same cycle: both happen and count is unchanged. On a full FIFO the pop frees a slot, so the push succeeds and overflow is not set. On an empty FIFO the pop returns 0 and the push lands.
  - A STATUS clear and a new error in the same cycle: the set wins.
- irq = (count!=0), registered. It updates the cycle after the count changes.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- common.v gains:
  - `KBD_BASE 32'ha1000000
  - `KBD_REG_DATA 2'd0 and `KBD_REG_STATUS 2'd1
  - STATUS bit index macros
- Reuses `MEM_READ, `DATA_BUS, `DATA_ZERO, `ENABLE.
- Sub-module ps2_rx holds the synchroniser, edge detect, FSM and timeout. Its outputs are byte[7:0], byte_valid and byte_err.
- The FIFO and bus logic stay in ps2_kbd_mmio.

Test Plan:
- Send frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at a 10 kHz PS/2 clock.
  - Expected: irq=1, STATUS=0x001.
  - Then read DATA: next cycle rdata=0x0000011C, irq=0 one cycle later, STATUS=0x400.
- Send 0x1C with parity 1.
  - Expected: FIFO empty, STATUS=0x600.
  - Then write STATUS wdata=0x200: STATUS=0x400.
- Send 17 good frames 0x00..0x10.
  - Expected: STATUS=0x110.
  - 16 DATA reads return 0x100..0x10F in order; a 17th read returns 0x00000000.
- Send 5 bits, idle 150 us, then a full frame 0xF0.
  - Expected: only 0xF0 is queued (count=1), frame_err=0.
- FIFO full with 16 entries; issue a DATA read in the exact cycle byte_valid pulses.
  - Expected: count stays 16, overflow=0, the new byte is the last entry.
- Assert rst mid-frame (after 4 bits), release, then send 0x5A.
  - Expected: outputs 0 immediately on rst; after release only 0x5A is queued.
